// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one external memory bus between
// the instruction-side and data-side requesters. It issues one registered
// valid/ready transaction at a time, tags it cacheable or uncached by address
// region, and aborts it with an error if the bus never answers.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; picks a winner and latches its fields
// BUS   | bus_valid high, waiting for bus_ready or timeout
// RESP  | one-cycle ack (with rdata/err) to the winner, then back to IDLE
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_ack,
    output logic [31:0] imem_rdata,
    output logic        imem_err,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_uncached,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Counter value at which a non-ready cycle aborts the transaction.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;          // 1 = dmem served last
    logic        win_q, win_d;            // 1 = dmem owns the bus
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        bus_uncached_q, bus_uncached_d;
    logic        imem_ack_q, imem_ack_d;
    logic        dmem_ack_q, dmem_ack_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        imem_err_q, imem_err_d;
    logic        dmem_err_q, dmem_err_d;
    logic        busy_q, busy_d;

    logic        grant_dmem;

    // Only the 4 MB regions with tag 0 and tag 2 are cacheable.
    function automatic logic is_uncached(input logic [31:0] addr);
        logic [9:0] tag;
        tag = addr[31:22];
        return !((tag == 10'h000) || (tag == 10'h002));
    endfunction

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign grant_dmem = dmem_req && (!imem_req || !last_q);

    // Next-state and datapath decisions for the arbiter FSM.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        win_d          = win_q;
        cnt_d          = cnt_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        bus_wstrb_d    = bus_wstrb_q;
        bus_uncached_d = bus_uncached_q;
        imem_ack_d     = 1'b0;
        dmem_ack_d     = 1'b0;
        imem_rdata_d   = imem_rdata_q;
        dmem_rdata_d   = dmem_rdata_q;
        imem_err_d     = imem_err_q;
        dmem_err_d     = dmem_err_q;

        case (state_q)
            ST_IDLE: begin
                if (imem_req || dmem_req) begin
                    win_d   = grant_dmem;
                    last_d  = grant_dmem;
                    cnt_d   = 8'd0;
                    state_d = ST_BUS;
                    if (grant_dmem) begin
                        bus_we_d       = dmem_we;
                        bus_addr_d     = dmem_addr;
                        bus_wdata_d    = dmem_wdata;
                        bus_wstrb_d    = dmem_wstrb;
                        bus_uncached_d = is_uncached(dmem_addr);
                    end else begin
                        bus_we_d       = 1'b0;
                        bus_addr_d     = imem_addr;
                        bus_wdata_d    = 32'd0;
                        bus_wstrb_d    = 4'hF;
                        bus_uncached_d = is_uncached(imem_addr);
                    end
                end
            end
            ST_BUS: begin
                // bus_ready wins over a timeout landing on the same cycle.
                if (bus_ready || (cnt_q == CNT_LAST)) begin
                    state_d = ST_RESP;
                    if (win_q) begin
                        dmem_ack_d   = 1'b1;
                        dmem_err_d   = !bus_ready;
                        dmem_rdata_d = (bus_ready && !bus_we_q) ? bus_rdata : 32'd0;
                    end else begin
                        imem_ack_d   = 1'b1;
                        imem_err_d   = !bus_ready;
                        imem_rdata_d = bus_ready ? bus_rdata : 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        bus_valid_d = (state_d == ST_BUS);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_q         <= 1'b0;
            win_q          <= 1'b0;
            cnt_q          <= 8'd0;
            bus_valid_q    <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'd0;
            bus_wdata_q    <= 32'd0;
            bus_wstrb_q    <= 4'd0;
            bus_uncached_q <= 1'b0;
            imem_ack_q     <= 1'b0;
            dmem_ack_q     <= 1'b0;
            imem_rdata_q   <= 32'd0;
            dmem_rdata_q   <= 32'd0;
            imem_err_q     <= 1'b0;
            dmem_err_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            win_q          <= win_d;
            cnt_q          <= cnt_d;
            bus_valid_q    <= bus_valid_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_wstrb_q    <= bus_wstrb_d;
            bus_uncached_q <= bus_uncached_d;
            imem_ack_q     <= imem_ack_d;
            dmem_ack_q     <= dmem_ack_d;
            imem_rdata_q   <= imem_rdata_d;
            dmem_rdata_q   <= dmem_rdata_d;
            imem_err_q     <= imem_err_d;
            dmem_err_q     <= dmem_err_d;
            busy_q         <= busy_d;
        end
    end

    assign imem_ack     = imem_ack_q;
    assign imem_rdata   = imem_rdata_q;
    assign imem_err     = imem_err_q;
    assign dmem_ack     = dmem_ack_q;
    assign dmem_rdata   = dmem_rdata_q;
    assign dmem_err     = dmem_err_q;
    assign bus_valid    = bus_valid_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wstrb    = bus_wstrb_q;
    assign bus_uncached = bus_uncached_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed cases plus randomized traffic, all
// checked against a transaction-level model of arbitration, region tagging
// and timeout behaviour.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk, rst;
    logic        imem_req, dmem_req, dmem_we, bus_ready;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, bus_rdata;
    logic [3:0]  dmem_wstrb;
    logic        imem_ack, imem_err, dmem_ack, dmem_err;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        bus_valid, bus_we, bus_uncached, busy;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_uncached(bus_uncached),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending requests per side and the round-robin pointer.
    bit          ip, dp, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dwstrb;
    bit          last_was_d;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_uncached(input logic [31:0] a);
        logic [9:0] tag;
        tag = a[31:22];
        return !(tag inside {10'h000, 10'h002});
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [9:0]  tag;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: tag = 10'h000;
            1: tag = 10'h001;
            2: tag = 10'h002;
            3: tag = 10'h003;
            4: tag = 10'h3FF;
            default: tag = r[31:22];
        endcase
        return {tag, r[21:0]};
    endfunction

    task automatic new_imem();
        ip = 1'b1;
        iaddr = rand_addr();
    endtask

    task automatic new_dmem();
        dp = 1'b1;
        dwe = 1'($urandom_range(0, 1));
        daddr = rand_addr();
        dwdata = $urandom;
        dwstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"},
                 {24'd0, imem_ack, dmem_ack, imem_err, dmem_err, bus_valid, bus_we, bus_uncached, busy}, 32'd0);
        check_eq({tag, "_imem_rdata"}, imem_rdata, 32'd0);
        check_eq({tag, "_dmem_rdata"}, dmem_rdata, 32'd0);
        check_eq({tag, "_bus_addr"}, bus_addr, 32'd0);
        check_eq({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check_eq({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    endtask

    // Runs one arbitration round starting in an IDLE cycle (time = posedge+1).
    // waits = non-ready BUS cycles before bus_ready; waits >= TO never answers.
    task automatic run_txn(input int waits, input logic [31:0] rdat, output bit won_d);
        bit          exp_err;
        int          exp_cycles, k;
        logic [31:0] exp_addr, exp_rdata;
        logic        exp_we;
        logic [3:0]  exp_wstrb;

        imem_req = ip;  imem_addr = iaddr;
        dmem_req = dp;  dmem_we = dwe; dmem_addr = daddr;
        dmem_wdata = dwdata; dmem_wstrb = dwstrb;
        bus_ready = 1'b0;

        won_d     = dp && (!ip || !last_was_d);
        exp_addr  = won_d ? daddr : iaddr;
        exp_we    = won_d ? dwe : 1'b0;
        exp_wstrb = won_d ? dwstrb : 4'hF;
        exp_err   = (waits >= TO);
        exp_cycles = exp_err ? TO : waits + 1;
        exp_rdata = (exp_err || exp_we) ? 32'd0 : rdat;

        @(posedge clk); #1;
        check_eq("busy_in_bus", {31'd0, busy}, 32'd1);
        k = 0;
        while (bus_valid && k < 20) begin
            check_eq("bus_addr", bus_addr, exp_addr);
            check_eq("bus_we", {31'd0, bus_we}, {31'd0, exp_we});
            check_eq("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, exp_wstrb});
            check_eq("bus_uncached", {31'd0, bus_uncached}, {31'd0, model_uncached(exp_addr)});
            if (won_d) check_eq("bus_wdata", bus_wdata, dwdata);
            bus_ready = (k == waits);
            bus_rdata = (k == waits) ? rdat : $urandom;
            @(posedge clk); #1;
            k++;
        end
        bus_ready = 1'b0;
        check_eq("valid_cycles", k, exp_cycles);
        check_eq("imem_ack", {31'd0, imem_ack}, {31'd0, !won_d});
        check_eq("dmem_ack", {31'd0, dmem_ack}, {31'd0, won_d});
        check_eq("rdata", won_d ? dmem_rdata : imem_rdata, exp_rdata);
        check_eq("err", {31'd0, won_d ? dmem_err : imem_err}, {31'd0, exp_err});

        last_was_d = won_d;
        if (won_d) begin dp = 1'b0; dmem_req = 1'b0; end
        else       begin ip = 1'b0; imem_req = 1'b0; end

        @(posedge clk); #1;
        check_eq("ack_one_cycle", {30'd0, imem_ack, dmem_ack}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        logic [31:0] r;

        imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_we = 0; dmem_addr = 0;
        dmem_wdata = 0; dmem_wstrb = 0; bus_ready = 0; bus_rdata = 0;
        ip = 0; dp = 0; dwe = 0; iaddr = 0; daddr = 0; dwdata = 0; dwstrb = 0;
        last_was_d = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Contention from reset: D, I, D, I.
        new_imem(); new_dmem();
        for (int i = 0; i < 4; i++) begin
            if (!ip) new_imem();
            if (!dp) new_dmem();
            run_txn(0, $urandom, w);
            check_eq("grant_order", {31'd0, w}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Single imem read, zero-wait.
        ip = 1; iaddr = 32'h0000_1000; dp = 0;
        run_txn(0, 32'hDEAD_BEEF, w);

        // Uncached / cached dmem writes with 3 wait states.
        dp = 1; dwe = 1; daddr = 32'h0040_0010; dwdata = 32'h1234_5678; dwstrb = 4'b0011;
        run_txn(3, 32'hCAFE_F00D, w);
        dp = 1; dwe = 1; daddr = 32'h0080_0000; dwdata = 32'hA5A5_0001; dwstrb = 4'b1100;
        run_txn(3, 32'hCAFE_F00D, w);
        dp = 1; dwe = 1; daddr = 32'hFFC0_0004; dwdata = 32'h0BAD_0002; dwstrb = 4'b1111;
        run_txn(3, 32'hCAFE_F00D, w);

        // Timeout, then ready landing on the last allowed cycle.
        ip = 1; iaddr = 32'h0000_2000;
        run_txn(99, 32'h1111_1111, w);
        dp = 1; dwe = 0; daddr = 32'h0080_0100; dwdata = 0; dwstrb = 4'hF;
        run_txn(99, 32'h2222_2222, w);
        ip = 1; iaddr = 32'h0000_3000;
        run_txn(TO - 1, 32'h3333_3333, w);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if (!ip && $urandom_range(0, 9) < 6) new_imem();
            if (!dp && $urandom_range(0, 9) < 6) new_dmem();
            if (!ip && !dp) begin
                if ($urandom_range(0, 1) == 1) new_imem(); else new_dmem();
            end
            r = $urandom;
            run_txn($urandom_range(0, TO + 1), r, w);
        end

        // Reset in the middle of a waiting transaction.
        new_imem(); dp = 0;
        imem_req = 1; imem_addr = iaddr; dmem_req = 0; bus_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("no_ack_in_reset", {30'd0, imem_ack, dmem_ack}, 32'd0);
        end
        rst = 1'b0;
        ip = 0; imem_req = 0; last_was_d = 0;
        new_imem(); new_dmem();
        run_txn(1, $urandom, w);
        check_eq("post_reset_tie", {31'd0, w}, 32'd1);
        run_txn(0, $urandom, w);
        check_eq("post_reset_next", {31'd0, w}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the processor's single external memory bus between the instruction-side and data-side requesters, which are the cache refill/uncached paths behind the imem and dmem ports. It grants one requester at a time with round-robin fairness and drives a registered valid/ready bus transaction. It tags each transaction cacheable or uncached using the fixed address-region rule, and it bounds every transaction with a timeout that returns an error.

## Interface
- `TIMEOUT`, default 255: maximum cycles `bus_valid` may wait for `bus_ready` before the transaction is aborted; range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` in 1: instruction-side read request; held high with stable `imem_addr` until `imem_ack`.
- `imem_addr` in 32: instruction read address.
- `imem_ack` out 1: one-cycle completion pulse.
- `imem_rdata` out 32: read data, valid while `imem_ack`=1.
- `imem_err` out 1: timeout error, valid while `imem_ack`=1.
- `dmem_req` in 1: data-side request; held high with stable `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` until `dmem_ack`.
- `dmem_we` in 1: 1 means write, 0 means read.
- `dmem_addr` in 32: data address.
- `dmem_wdata` in 32: write data.
- `dmem_wstrb` in 4: byte enables.
- `dmem_ack` out 1: one-cycle completion pulse.
- `dmem_rdata` out 32: read data, valid while `dmem_ack`=1; it is 0 for writes.
- `dmem_err` out 1: timeout error, valid while `dmem_ack`=1.
- `bus_valid` out 1: transaction valid; held until `bus_ready` or timeout.
- `bus_we` out 1: registered write flag; always 0 for imem transactions.
- `bus_addr` out 32: registered address.
- `bus_wdata` out 32: registered write data.
- `bus_wstrb` out 4: registered byte enables; 4'hF for imem transactions.
- `bus_uncached` out 1: registered region flag for the current transaction.
- `bus_ready` in 1: bus accepts or completes the transaction this cycle.
- `bus_rdata` in 32: read data, valid when `bus_valid && bus_ready`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, BUS and RESP.
- **IDLE.** Sample `imem_req` and `dmem_req`.
  - If either request is high, pick a winner, latch its request fields into the `bus_*` registers, clear the timeout counter and go to BUS.
  - If both are high, the winner is the requester not served last. The `last` pointer resets to imem, so dmem wins the first tie.
  - If only one is high, that requester wins. `last` updates to the winner in every case.
- **Region rule.** `bus_uncached` = 0 when `addr[31:22]` is 10'h0 or 10'h2, and 1 for every other value, including 10'h1. It is computed from the winning address and registered together with it.
- **BUS.** `bus_valid`=1.
  - On a cycle with `bus_ready`=1: capture `bus_rdata` into the winner's rdata register (for dmem writes, capture 0 instead), set err=0, drop `bus_valid` and go to RESP.
  - Otherwise increment the counter. When the counter equals `TIMEOUT`-1 on a non-ready cycle, set rdata=0 and err=1, drop `bus_valid` and go to RESP.
  - `bus_ready` arriving on the same cycle as the timeout compare takes priority, and the transaction completes without error.
- **RESP.** Pulse the winner's ack for exactly one cycle, then go to IDLE. The other ack stays 0.
- Each requester must deassert or change its request on the edge after it sees ack. Its request is not re-sampled until the next IDLE cycle.
- The losing requester keeps `req` high and is served in the next IDLE cycle. With continuous requests from both sides, grants alternate strictly I, D, I, D after the first D.
- Request inputs are ignored outside IDLE.
- **Reset,** including reset mid-transaction: state returns to IDLE, `last` returns to imem, and the counter clears.
  - All outputs go to 0 on reset: acks, errs, rdata buses, `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `bus_uncached` and `busy`.
  - An aborted transaction is never acked.

## Timing
- Request high in IDLE at edge N: `bus_valid`=1 and `busy`=1 from edge N+1.
- Zero-wait bus (`bus_ready` high in the first BUS cycle): ack at N+2, IDLE at N+3.
- Each wait cycle adds one cycle of latency.
- Back-to-back throughput is one transaction per 3 cycles minimum.
- Timeout path: `bus_valid` is high for exactly `TIMEOUT` cycles, then ack with err=1 on the next cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `bus_*` fields hold stable for the entire BUS state.

## Test plan
- **Single imem read.** Drive `imem_addr`=0x0000_1000 with `bus_ready` tied 1 and `bus_rdata`=0xDEADBEEF. Expect: `bus_uncached`=0, `bus_wstrb`=4'hF, `imem_ack` 2 cycles after the request is sampled, `imem_rdata`=0xDEADBEEF, `imem_err`=0.
- **Uncached dmem write.** Drive `dmem_addr`=0x0040_0010 (tag 1) with `dmem_wdata`=0x12345678 and `wstrb`=4'b0011, and insert 3 wait cycles on `bus_ready`. Expect: `bus_uncached`=1, `bus_we`=1, fields stable for 4 BUS cycles, then `dmem_ack` with rdata=0. Repeat with tag 2 (0x0080_0000) and expect `bus_uncached`=0; with tag 0x3FF, expect `bus_uncached`=1.
- **Contention.** Hold both requests high out of reset. Expect grant order D, I, D, I over 4 transactions, with exactly one ack per transaction.
- **Timeout.** Set `TIMEOUT`=4 and keep `bus_ready`=0. Expect `bus_valid` high for 4 cycles, then the requester's ack with err=1 and rdata=0. Separately, assert `bus_ready` on the 4th cycle and expect err=0.
- **Reset mid-transaction.** Assert `rst` during BUS with wait states. Expect all outputs 0 immediately (asynchronously) and no ack. After release, a tie grants dmem first.
